// File: rtl/ex_ls_stage_buf.sv
// rtl/ex_ls_stage_buf.sv - EX->LS stage register with 2-entry skid buffer and registered in_ready.
// Optional perf counters enabled by defining LS_BUF_PERF_EN.
module ex_ls_stage_buf #(
    parameter int unsigned       XLEN      = 64,
    parameter int unsigned       ILEN      = 32,
    parameter int unsigned       CTRL_W    = 5,
    parameter logic [ILEN-1:0]   NOP_INSTR = 'h00000013
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [ILEN-1:0]   instr_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [XLEN-1:0]   alures_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   pc_o,
    output logic [ILEN-1:0]   instr_o,
    output logic [XLEN-1:0]   rs2_o,
    output logic [XLEN-1:0]   alures_o,
`ifdef LS_BUF_PERF_EN
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       bubble_cnt_o
`else
    output logic [CTRL_W-1:0] ctrl_o
`endif
);

    localparam int unsigned PW = 3 * XLEN + ILEN + CTRL_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic [PW-1:0] in_bus;
    logic          in_fire;
    logic          out_fire;

    assign in_bus   = {pc_i, instr_i, rs2_i, alures_i, ctrl_i};
    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = out_valid_q & out_ready_i;

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign {pc_o, instr_o, rs2_o, alures_o, ctrl_o} = main_q;

    // Ready and valid are registered alongside the state so neither has a combinational path.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= {{XLEN{1'b0}}, NOP_INSTR, {(2 * XLEN + CTRL_W){1'b0}}};
            skid_q      <= '0;
        end else if (flush_i) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_q      <= in_bus;
                        state_q     <= BUSY;
                        out_valid_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_bus;
                    end else if (in_fire) begin
                        skid_q     <= in_bus;
                        state_q    <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q     <= skid_q;
                        state_q    <= BUSY;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef LS_BUF_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;

    // Saturating counters; flush deliberately does not clear them.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid_q && !out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!out_valid_q && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_ls_stage_buf.sv
// tb/tb_ex_ls_stage_buf.sv - scoreboard bench for ex_ls_stage_buf.
module tb_ex_ls_stage_buf;

    localparam int PW = 3 * 64 + 32 + 5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [63:0] pc_i = '0;
    logic [31:0] instr_i = '0;
    logic [63:0] rs2_i = '0;
    logic [63:0] alures_i = '0;
    logic [4:0]  ctrl_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [63:0] pc_o;
    logic [31:0] instr_o;
    logic [63:0] rs2_o;
    logic [63:0] alures_o;
    logic [4:0]  ctrl_o;
`ifdef LS_BUF_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] bubble_cnt_o;
`endif

    int total = 0;
    int bad   = 0;
    logic [PW-1:0] sb_q[$];

    always #5 clk = ~clk;

    ex_ls_stage_buf dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .pc_i         (pc_i),
        .instr_i      (instr_i),
        .rs2_i        (rs2_i),
        .alures_i     (alures_i),
        .ctrl_i       (ctrl_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .pc_o         (pc_o),
        .instr_o      (instr_o),
        .rs2_o        (rs2_o),
        .alures_o     (alures_o),
`ifdef LS_BUF_PERF_EN
        .ctrl_o       (ctrl_o),
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
`else
        .ctrl_o       (ctrl_o)
`endif
    );

    function automatic logic [PW-1:0] mk(input logic [63:0] pc);
        return {pc, pc[31:0] ^ 32'hA5A5_0F0F, ~pc, pc + 64'h1000, pc[6:2]};
    endfunction

    // Drives one cycle starting just after a falling edge; reports handshakes seen before the rising edge.
    task automatic step(input logic v, input logic [63:0] pc, input logic rdy, input logic fl,
                        output logic acc, output logic fired, output logic [PW-1:0] obs);
        in_valid_i  = v;
        {pc_i, instr_i, rs2_i, alures_i, ctrl_i} = mk(pc);
        out_ready_i = rdy;
        flush_i     = fl;
        #1;
        acc   = v & in_ready_o & ~fl;
        fired = out_valid_o & rdy;
        obs   = {pc_o, instr_o, rs2_o, alures_o, ctrl_o};
        @(posedge clk);
        @(negedge clk);
        in_valid_i  = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic test_reset();
        logic acc, fired;
        logic [PW-1:0] obs;
        step(1'b1, 64'hA000, 1'b0, 1'b0, acc, fired, obs);
        step(1'b1, 64'hB000, 1'b0, 1'b0, acc, fired, obs);
        rstn = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid_o); end
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready_o); end
        total++; if (instr_o !== 32'h00000013) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", instr_o); end
        total++; if ({pc_o, rs2_o, alures_o, ctrl_o} !== '0) begin bad++; $display("FAIL rst_payload got=%h exp=0", {pc_o, rs2_o, alures_o, ctrl_o}); end
`ifdef LS_BUF_PERF_EN
        total++; if ({stall_cnt_o, bubble_cnt_o} !== 64'd0) begin bad++; $display("FAIL rst_counters got=%h exp=0", {stall_cnt_o, bubble_cnt_o}); end
`endif
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        sb_q.delete();
        step(1'b0, 64'h0, 1'b1, 1'b0, acc, fired, obs);
        total++; if (fired !== 1'b0) begin bad++; $display("FAIL rst_entries_lost got=%b exp=0", fired); end
    endtask

    task automatic test_streaming();
        logic acc, fired;
        logic [PW-1:0] obs, exp;
        for (int k = 0; k <= 8; k++) begin
            step(k < 8, 64'h8000_0000 + 64'(4 * k), 1'b1, 1'b0, acc, fired, obs);
            total++;
            if (fired !== (k > 0)) begin bad++; $display("FAIL stream_latency k=%0d got=%b exp=%b", k, fired, k > 0); end
            if (fired === 1'b1) begin
                total++;
                if (sb_q.size() == 0) begin bad++; $display("FAIL stream_extra got=%h exp=none", obs); end
                else begin
                    exp = sb_q.pop_front();
                    if (obs !== exp) begin bad++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, obs, exp); end
                end
            end
            if (k < 8) begin
                total++;
                if (acc !== 1'b1) begin bad++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, acc); end
                sb_q.push_back(mk(64'h8000_0000 + 64'(4 * k)));
            end
        end
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL stream_drain got=%0d exp=0", sb_q.size()); end
    endtask

    task automatic test_back_pressure();
        logic acc, fired;
        logic [PW-1:0] obs, exp;
        logic [63:0] pcs[3];
        pcs[0] = 64'h1000; pcs[1] = 64'h2000; pcs[2] = 64'h3000;
        step(1'b1, pcs[0], 1'b0, 1'b0, acc, fired, obs);
        if (acc) sb_q.push_back(mk(pcs[0]));
        step(1'b1, pcs[1], 1'b0, 1'b0, acc, fired, obs);
        if (acc) sb_q.push_back(mk(pcs[1]));
        total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b exp=0", in_ready_o); end
        total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", out_valid_o); end
        step(1'b1, pcs[2], 1'b0, 1'b0, acc, fired, obs);
        total++; if (acc !== 1'b0) begin bad++; $display("FAIL bp_c_rejected got=%b exp=0", acc); end
        total++; if (obs !== mk(pcs[0])) begin bad++; $display("FAIL bp_stable got=%h exp=%h", obs, mk(pcs[0])); end
        for (int k = 0; k < 5; k++) begin
            step(1'b1, pcs[2], 1'b1, 1'b0, acc, fired, obs);
            if (fired === 1'b1) begin
                total++;
                if (sb_q.size() == 0) begin bad++; $display("FAIL bp_extra got=%h exp=none", obs); end
                else begin
                    exp = sb_q.pop_front();
                    if (obs !== exp) begin bad++; $display("FAIL bp_order k=%0d got=%h exp=%h", k, obs, exp); end
                end
            end
            if (acc === 1'b1) begin
                sb_q.push_back(mk(pcs[2]));
                break;
            end
        end
        step(1'b0, 64'h0, 1'b1, 1'b0, acc, fired, obs);
        total++;
        if (fired !== 1'b1 || sb_q.size() == 0) begin bad++; $display("FAIL bp_c_missing got=%b exp=1", fired); end
        else begin
            exp = sb_q.pop_front();
            if (obs !== exp) begin bad++; $display("FAIL bp_c_data got=%h exp=%h", obs, exp); end
        end
        step(1'b0, 64'h0, 1'b1, 1'b0, acc, fired, obs);
        total++; if (fired !== 1'b0 || sb_q.size() != 0) begin bad++; $display("FAIL bp_drain got=%b/%0d exp=0/0", fired, sb_q.size()); end
    endtask

    task automatic test_flush_full();
        logic acc, fired;
        logic [PW-1:0] obs, exp;
        step(1'b1, 64'hC100, 1'b0, 1'b0, acc, fired, obs);
        step(1'b1, 64'hC200, 1'b0, 1'b0, acc, fired, obs);
        step(1'b1, 64'hDDDD, 1'b0, 1'b1, acc, fired, obs);
        sb_q.delete();
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL ff_valid got=%b exp=0", out_valid_o); end
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL ff_ready got=%b exp=1", in_ready_o); end
        step(1'b0, 64'h0, 1'b1, 1'b0, acc, fired, obs);
        total++; if (fired !== 1'b0) begin bad++; $display("FAIL ff_d_appeared got=%h exp=none", obs); end
        step(1'b1, 64'hE000, 1'b1, 1'b0, acc, fired, obs);
        if (acc) sb_q.push_back(mk(64'hE000));
        step(1'b0, 64'h0, 1'b1, 1'b0, acc, fired, obs);
        total++;
        if (fired !== 1'b1 || sb_q.size() == 0) begin bad++; $display("FAIL ff_e_missing got=%b exp=1", fired); end
        else begin
            exp = sb_q.pop_front();
            if (obs !== exp) begin bad++; $display("FAIL ff_e_data got=%h exp=%h", obs, exp); end
        end
    endtask

    task automatic test_flush_fire();
        logic acc, fired;
        logic [PW-1:0] obs, exp;
        int delivered;
        step(1'b1, 64'h5000, 1'b0, 1'b0, acc, fired, obs);
        if (acc) sb_q.push_back(mk(64'h5000));
        step(1'b1, 64'h6000, 1'b0, 1'b0, acc, fired, obs);
        if (acc) sb_q.push_back(mk(64'h6000));
        step(1'b0, 64'h0, 1'b1, 1'b1, acc, fired, obs);
        delivered = 0;
        total++;
        if (fired !== 1'b1 || sb_q.size() == 0) begin bad++; $display("FAIL fo_a_fire got=%b exp=1", fired); end
        else begin
            exp = sb_q.pop_front();
            delivered++;
            if (obs !== exp) begin bad++; $display("FAIL fo_a_data got=%h exp=%h", obs, exp); end
        end
        sb_q.delete();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 64'h0, 1'b1, 1'b0, acc, fired, obs);
            if (fired === 1'b1) delivered++;
        end
        total++; if (delivered != 1) begin bad++; $display("FAIL fo_delivered got=%0d exp=1", delivered); end
    endtask

`ifdef LS_BUF_PERF_EN
    task automatic test_perf();
        logic acc, fired;
        logic [PW-1:0] obs;
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        step(1'b0, 64'h0, 1'b0, 1'b0, acc, fired, obs);
        step(1'b1, 64'h7000, 1'b0, 1'b0, acc, fired, obs);
        for (int k = 0; k < 3; k++) step(1'b0, 64'h0, 1'b0, 1'b0, acc, fired, obs);
        total++; if (stall_cnt_o !== 32'd3) begin bad++; $display("FAIL perf_stall got=%0d exp=3", stall_cnt_o); end
        total++; if (bubble_cnt_o !== 32'd2) begin bad++; $display("FAIL perf_bubble got=%0d exp=2", bubble_cnt_o); end
        step(1'b0, 64'h0, 1'b0, 1'b1, acc, fired, obs);
        step(1'b0, 64'h0, 1'b0, 1'b0, acc, fired, obs);
        total++; if (stall_cnt_o !== 32'd4) begin bad++; $display("FAIL perf_stall_flush got=%0d exp=4", stall_cnt_o); end
        total++; if (bubble_cnt_o !== 32'd3) begin bad++; $display("FAIL perf_bubble_flush got=%0d exp=3", bubble_cnt_o); end
        sb_q.delete();
    endtask
`endif

    initial begin
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush_full();
        test_flush_fire();
`ifdef LS_BUF_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
